second_cache_trace: RTL
=======================

SECOND_CACHE_TRACE -- requirements
Module: second_cache_trace

Interface
REQ-001 The block SHALL have no parameters; widths SHALL come from the shared defines (INST_NUM = 4, SINGLE_WORD = 32, EXCCODE = 5).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports exactly as listed in REQ-003 and REQ-004.
REQ-003 clk  in  1  clock, then rst  in  1  asynchronous active-low reset.
REQ-004 The block SHALL provide these ports, name direction width meaning:
- FCT_valid_i  in  1  first stage holds a request.
- FCT_VAddr_i  in  32  fetch group base VA.
- FCT_originEnable_i  in  4  PC-register lane mask.
- FCT_BTBInstEnable_i  in  4  BTB lane mask.
- FCT_predDest_p_i  in  128  per-lane predicted targets.
- FCT_BTBValidTake_i  in  1  final prediction taken.
- FCT_BTBValidDest_i  in  32  final prediction target.
- FCT_hasException_i  in  1  fetch exception.
- FCT_ExcCode_i  in  5  exception code.
- FCT_isCanceled_i  in  1  request already killed.
- BSC_needCancel_w_i  in  1  branch-check flush.
- CP0_excOccur_w_i  in  1  exception flush.
- inst_data_ok  in  1  cache returns data this cycle.
- inst_rdata  in  128  four instruction words, lane 0 in the low bits.
- IQ_allowin_i  in  1  instruction queue accepts this cycle.
- SCT_allowin_w_o  out  1  stage can accept a request.
- SCT_valid_o  out  1  output group valid.
- SCT_inst_o  out  128  instructions.
- SCT_VAddr_o  out  32  group VA.
- SCT_instEnable_o  out  4  valid lanes.
- SCT_predDest_p_o  out  128  per-lane targets.
- SCT_BTBValidTake_o  out  1  taken.
- SCT_BTBValidDest_o  out  32  target.
- SCT_hasException_o  out  1  exception.
- SCT_ExcCode_o  out  5  code.

Function
REQ-005 The block SHALL implement a state machine with states IDLE, WAIT (data outstanding), HOLD (group registered, awaiting queue) and DRAIN (killed, data still outstanding).
REQ-006 SCT_allowin_w_o SHALL be 1 in IDLE, and in HOLD when IQ_allowin_i=1; it SHALL be 0 in WAIT and DRAIN.
REQ-007 A request SHALL be accepted on an edge where FCT_valid_i and SCT_allowin_w_o are both 1; at that edge all FCT_* side fields SHALL be latched.
REQ-008 On acceptance without exception, the next state SHALL be WAIT; if FCT_isCanceled_i or a flush (BSC_needCancel_w_i or CP0_excOccur_w_i) is also asserted, the next state SHALL be DRAIN.
REQ-009 On acceptance with FCT_hasException_i=1, no cache data is expected: the next state SHALL be HOLD with SCT_inst_o=0 and SCT_instEnable_o=4'b0001, or IDLE if the request is canceled or flushed.
REQ-010 In WAIT, when inst_data_ok=1, the block SHALL register inst_rdata and go to HOLD, giving one-cycle latency from data_ok to SCT_valid_o.
REQ-011 In WAIT, a flush without data_ok SHALL move to DRAIN; a flush in the same cycle as data_ok SHALL discard the data and move to IDLE.
REQ-012 In DRAIN, the block SHALL wait for inst_data_ok, discard the data and go to IDLE, ignoring further flushes.
REQ-013 SCT_valid_o SHALL be 1 only in HOLD and only when no flush is asserted in that cycle; a flush in HOLD SHALL force IDLE.
REQ-014 The group SHALL transfer when SCT_valid_o and IQ_allowin_i are both 1; on transfer the next state SHALL be WAIT, DRAIN or HOLD if a new request is accepted simultaneously (per REQ-008/009), else IDLE.
REQ-015 SCT_instEnable_o SHALL equal FCT_originEnable_i & FCT_BTBInstEnable_i as latched, except as REQ-009 specifies.
REQ-016 inst_data_ok in IDLE or HOLD SHALL be ignored and SHALL NOT change state.

Reset
REQ-017 While rst=0, state SHALL be IDLE, SCT_valid_o=0 and every data output SHALL be 0, with SCT_ExcCode_o = NOEXCCODE; the block SHALL recover from reset mid-WAIT or mid-DRAIN without an outstanding-data record.

Structure
REQ-018 State encoding and the NOEXCCODE, ZEROWORD and INST_NUM constants SHALL reside in the shared defines file.
REQ-019 The block SHALL be a single module with no sub-module.

Verification
REQ-020 The bench SHALL cover accept VA=0xBFC00000, masks 4'b1111 and 4'b0011, data_ok two cycles later with rdata words 1..4, IQ ready -> SCT_valid_o one cycle after data_ok, instEnable=4'b0011, inst=words 1..4.
REQ-021 The bench SHALL cover IQ_allowin_i=0 for 3 cycles in HOLD -> outputs stable, allowin=0, and a single transfer when ready.
REQ-022 The bench SHALL cover BSC_needCancel_w_i pulsed in WAIT, then data_ok 2 cycles later -> no SCT_valid_o, allowin=1 one cycle after data_ok.
REQ-023 The bench SHALL cover FCT_hasException_i=1 with ExcCode=4 (AdEL) -> HOLD next cycle with inst=0, enable=4'b0001, no data_ok required.
REQ-024 The bench SHALL cover back-to-back groups with IQ always ready -> transfer and accept on the same edge, no bubble beyond cache latency.
REQ-025 The bench SHALL cover rst deasserted-then-asserted while in WAIT -> all outputs 0 immediately, and a stray data_ok afterward ignored.

Source files
------------

// File: rtl/second_cache_trace_pkg.sv
// Shared widths, constants and state encoding for the second cache stage of the fetch pipe.
package second_cache_trace_pkg;
    localparam int INST_NUM    = 4;
    localparam int SINGLE_WORD = 32;
    localparam int EXCCODE     = 5;
    localparam int GROUP_W     = INST_NUM * SINGLE_WORD;

    localparam logic [EXCCODE-1:0]     NOEXCCODE = 5'h1f;
    localparam logic [SINGLE_WORD-1:0] ZEROWORD  = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } sct_state_e;
endpackage

// File: rtl/second_cache_trace_if.sv
// Fetch-stage request, cache return and instruction-queue handshake for second_cache_trace.
interface second_cache_trace_if;
    import second_cache_trace_pkg::*;

    logic                   FCT_valid_i;
    logic [SINGLE_WORD-1:0] FCT_VAddr_i;
    logic [INST_NUM-1:0]    FCT_originEnable_i;
    logic [INST_NUM-1:0]    FCT_BTBInstEnable_i;
    logic [GROUP_W-1:0]     FCT_predDest_p_i;
    logic                   FCT_BTBValidTake_i;
    logic [SINGLE_WORD-1:0] FCT_BTBValidDest_i;
    logic                   FCT_hasException_i;
    logic [EXCCODE-1:0]     FCT_ExcCode_i;
    logic                   FCT_isCanceled_i;
    logic                   BSC_needCancel_w_i;
    logic                   CP0_excOccur_w_i;
    logic                   inst_data_ok;
    logic [GROUP_W-1:0]     inst_rdata;
    logic                   IQ_allowin_i;

    logic                   SCT_allowin_w_o;
    logic                   SCT_valid_o;
    logic [GROUP_W-1:0]     SCT_inst_o;
    logic [SINGLE_WORD-1:0] SCT_VAddr_o;
    logic [INST_NUM-1:0]    SCT_instEnable_o;
    logic [GROUP_W-1:0]     SCT_predDest_p_o;
    logic                   SCT_BTBValidTake_o;
    logic [SINGLE_WORD-1:0] SCT_BTBValidDest_o;
    logic                   SCT_hasException_o;
    logic [EXCCODE-1:0]     SCT_ExcCode_o;

    modport slave (
        input  FCT_valid_i, FCT_VAddr_i, FCT_originEnable_i, FCT_BTBInstEnable_i,
               FCT_predDest_p_i, FCT_BTBValidTake_i, FCT_BTBValidDest_i,
               FCT_hasException_i, FCT_ExcCode_i, FCT_isCanceled_i,
               BSC_needCancel_w_i, CP0_excOccur_w_i, inst_data_ok, inst_rdata, IQ_allowin_i,
        output SCT_allowin_w_o, SCT_valid_o, SCT_inst_o, SCT_VAddr_o, SCT_instEnable_o,
               SCT_predDest_p_o, SCT_BTBValidTake_o, SCT_BTBValidDest_o,
               SCT_hasException_o, SCT_ExcCode_o
    );

    modport master (
        output FCT_valid_i, FCT_VAddr_i, FCT_originEnable_i, FCT_BTBInstEnable_i,
               FCT_predDest_p_i, FCT_BTBValidTake_i, FCT_BTBValidDest_i,
               FCT_hasException_i, FCT_ExcCode_i, FCT_isCanceled_i,
               BSC_needCancel_w_i, CP0_excOccur_w_i, inst_data_ok, inst_rdata, IQ_allowin_i,
        input  SCT_allowin_w_o, SCT_valid_o, SCT_inst_o, SCT_VAddr_o, SCT_instEnable_o,
               SCT_predDest_p_o, SCT_BTBValidTake_o, SCT_BTBValidDest_o,
               SCT_hasException_o, SCT_ExcCode_o
    );
endinterface

// File: rtl/second_cache_trace.sv
// Second cache stage: waits for the instruction-cache return of an accepted fetch group,
// holds it until the instruction queue takes it, and drops data belonging to killed requests.
module second_cache_trace
    import second_cache_trace_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    second_cache_trace_if.slave  bus
);
    sct_state_e state, next_state, accept_state;
    logic flush, allowin, accept, kill;

    logic [GROUP_W-1:0]     inst_q;
    logic [SINGLE_WORD-1:0] vaddr_q;
    logic [INST_NUM-1:0]    enable_q;
    logic [GROUP_W-1:0]     pred_q;
    logic                   take_q;
    logic [SINGLE_WORD-1:0] dest_q;
    logic                   exc_q;
    logic [EXCCODE-1:0]     code_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        flush   = bus.BSC_needCancel_w_i | bus.CP0_excOccur_w_i;
        allowin = (state == S_IDLE) | ((state == S_HOLD) & bus.IQ_allowin_i);
        accept  = bus.FCT_valid_i & allowin;
        kill    = bus.FCT_isCanceled_i | flush;
        // Exception groups carry no cache access, so a killed one has nothing left to drain.
        if (bus.FCT_hasException_i) accept_state = kill ? S_IDLE  : S_HOLD;
        else                        accept_state = kill ? S_DRAIN : S_WAIT;

        next_state = state;
        case (state)
            S_IDLE:  if (accept) next_state = accept_state;
            S_WAIT: begin
                if (bus.inst_data_ok) next_state = flush ? S_IDLE : S_HOLD;
                else if (flush)       next_state = S_DRAIN;
            end
            S_HOLD: begin
                // accept implies the queue is ready, so the held group leaves on this edge too.
                if (accept)                         next_state = accept_state;
                else if (flush | bus.IQ_allowin_i)  next_state = S_IDLE;
            end
            S_DRAIN: if (bus.inst_data_ok) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_q   <= '0;
            vaddr_q  <= ZEROWORD;
            enable_q <= '0;
            pred_q   <= '0;
            take_q   <= 1'b0;
            dest_q   <= ZEROWORD;
            exc_q    <= 1'b0;
            code_q   <= NOEXCCODE;
        end else if (accept) begin
            inst_q   <= '0;
            vaddr_q  <= bus.FCT_VAddr_i;
            enable_q <= bus.FCT_hasException_i ? 4'b0001
                                               : (bus.FCT_originEnable_i & bus.FCT_BTBInstEnable_i);
            pred_q   <= bus.FCT_predDest_p_i;
            take_q   <= bus.FCT_BTBValidTake_i;
            dest_q   <= bus.FCT_BTBValidDest_i;
            exc_q    <= bus.FCT_hasException_i;
            code_q   <= bus.FCT_ExcCode_i;
        end else if ((state == S_WAIT) && bus.inst_data_ok && !flush) begin
            inst_q   <= bus.inst_rdata;
        end
    end

    assign bus.SCT_allowin_w_o    = allowin;
    assign bus.SCT_valid_o        = (state == S_HOLD) & ~flush;
    assign bus.SCT_inst_o         = inst_q;
    assign bus.SCT_VAddr_o        = vaddr_q;
    assign bus.SCT_instEnable_o   = enable_q;
    assign bus.SCT_predDest_p_o   = pred_q;
    assign bus.SCT_BTBValidTake_o = take_q;
    assign bus.SCT_BTBValidDest_o = dest_q;
    assign bus.SCT_hasException_o = exc_q;
    assign bus.SCT_ExcCode_o      = code_q;
endmodule
